// File: rtl/cw305_usb_bus_master.sv
// Bus initiator for the CW305 parallel USB register port: turns byte-burst commands into
// nCS/nRD/nWE cycles. Optional write-stall abort is compiled in with USB_MASTER_STALL_TIMEOUT_EN.
module cw305_usb_bus_master #(
    parameter int pADDR_WIDTH    = 21,
    parameter int pBYTECNT_SIZE  = 7,
    parameter int pLEN_WIDTH     = 8,
    parameter int pSETUP_CYCLES  = 2,
    parameter int pSTROBE_CYCLES = 3,
    parameter int pHOLD_CYCLES   = 1,
    parameter int pTIMEOUT       = 255
) (
    input  logic                   usb_clk,
    input  logic                   reset,
    input  logic                   I_cmd_valid,
    output logic                   O_cmd_ready,
    input  logic                   I_cmd_write,
    input  logic [pADDR_WIDTH-1:0] I_cmd_addr,
    input  logic [pLEN_WIDTH-1:0]  I_cmd_len,
    input  logic                   I_wr_valid,
    input  logic [7:0]             I_wr_data,
    output logic                   O_wr_ready,
    output logic                   O_rsp_valid,
    output logic [7:0]             O_rsp_data,
    output logic                   O_rsp_last,
    output logic                   O_busy,
    output logic                   O_error,
    output logic [pADDR_WIDTH-1:0] O_usb_addr,
    output logic [7:0]             O_usb_dout,
    output logic                   O_usb_drive,
    input  logic [7:0]             I_usb_din,
    output logic                   O_usb_ncs,
    output logic                   O_usb_nrd,
    output logic                   O_usb_nwe
);
    localparam int MAX_A   = (pSETUP_CYCLES > pSTROBE_CYCLES) ? pSETUP_CYCLES : pSTROBE_CYCLES;
    localparam int MAX_CYC = (MAX_A > pHOLD_CYCLES) ? MAX_A : pHOLD_CYCLES;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_STROBE, ST_HOLD} state_t;

    state_t                   state_q, state_d;
    logic                     write_q, write_d;
    logic [pADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [pLEN_WIDTH-1:0]    remaining_q, remaining_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     have_beat_q, have_beat_d;
    logic                     cmd_ready_q, cmd_ready_d;
    logic                     wr_ready_q, wr_ready_d;
    logic                     rsp_valid_q, rsp_valid_d;
    logic [7:0]               rsp_data_q, rsp_data_d;
    logic                     rsp_last_q, rsp_last_d;
    logic                     busy_q, busy_d;
    logic [7:0]               dout_q, dout_d;
    logic                     drive_q, drive_d;
    logic                     ncs_q, ncs_d;
    logic                     nrd_q, nrd_d;
    logic                     nwe_q, nwe_d;
    logic                     beat_take;
    logic                     counting;
`ifdef USB_MASTER_STALL_TIMEOUT_EN
    localparam int STALL_W = (pTIMEOUT > 1) ? $clog2(pTIMEOUT) : 1;
    logic [STALL_W-1:0]       stall_q, stall_d;
    logic                     error_q, error_d;
`endif

    always_comb begin
        state_d     = state_q;
        write_d     = write_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        cnt_d       = cnt_q;
        have_beat_d = have_beat_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        rsp_last_d  = 1'b0;
        dout_d      = dout_q;
        beat_take   = 1'b0;
        counting    = 1'b0;
`ifdef USB_MASTER_STALL_TIMEOUT_EN
        stall_d     = stall_q;
        error_d     = error_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (I_cmd_valid && cmd_ready_q) begin
                    state_d     = ST_SETUP;
                    write_d     = I_cmd_write;
                    addr_d      = I_cmd_addr;
                    remaining_d = I_cmd_len;
                    cnt_d       = '0;
                    have_beat_d = 1'b0;
`ifdef USB_MASTER_STALL_TIMEOUT_EN
                    stall_d     = '0;
`endif
                end
            end
            ST_SETUP: begin
                // A write only starts timing its setup once the data beat has arrived.
                beat_take = write_q && !have_beat_q && I_wr_valid && wr_ready_q;
                counting  = !write_q || have_beat_q || beat_take;
                if (beat_take) begin
                    dout_d      = I_wr_data;
                    have_beat_d = 1'b1;
                end
                if (counting) begin
                    if (cnt_q == CNT_W'(pSETUP_CYCLES - 1)) begin
                        cnt_d   = '0;
                        state_d = ST_STROBE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
`ifdef USB_MASTER_STALL_TIMEOUT_EN
                else if (stall_q == STALL_W'(pTIMEOUT - 1)) begin
                    state_d = ST_IDLE;
                    error_d = 1'b1;
                    stall_d = '0;
                end else begin
                    stall_d = stall_q + STALL_W'(1);
                end
`endif
            end
            ST_STROBE: begin
                if (cnt_q == CNT_W'(pSTROBE_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_HOLD;
                    if (!write_q) begin
                        rsp_valid_d = 1'b1;
                        rsp_data_d  = I_usb_din;
                        rsp_last_d  = (remaining_q == '0);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_HOLD: begin
                if (cnt_q == CNT_W'(pHOLD_CYCLES - 1)) begin
                    cnt_d = '0;
                    if (remaining_q == '0) begin
                        state_d = ST_IDLE;
                    end else begin
                        // Byte index wraps inside the register; the register select bits stay put.
                        state_d     = ST_SETUP;
                        remaining_d = remaining_q - pLEN_WIDTH'(1);
                        addr_d      = {addr_q[pADDR_WIDTH-1:pBYTECNT_SIZE],
                                       addr_q[pBYTECNT_SIZE-1:0] + pBYTECNT_SIZE'(1)};
                        have_beat_d = 1'b0;
`ifdef USB_MASTER_STALL_TIMEOUT_EN
                        stall_d     = '0;
`endif
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        cmd_ready_d = (state_d == ST_IDLE);
        busy_d      = (state_d != ST_IDLE);
        ncs_d       = (state_d == ST_IDLE);
        drive_d     = (state_d != ST_IDLE) && write_d;
        nwe_d       = !((state_d == ST_STROBE) && write_d);
        nrd_d       = !((state_d == ST_STROBE) && !write_d);
        wr_ready_d  = (state_d == ST_SETUP) && write_d && !have_beat_d;
    end

    always_ff @(posedge usb_clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            write_q     <= 1'b0;
            addr_q      <= '0;
            remaining_q <= '0;
            cnt_q       <= '0;
            have_beat_q <= 1'b0;
            cmd_ready_q <= 1'b0;
            wr_ready_q  <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            dout_q      <= '0;
            drive_q     <= 1'b0;
            ncs_q       <= 1'b1;
            nrd_q       <= 1'b1;
            nwe_q       <= 1'b1;
`ifdef USB_MASTER_STALL_TIMEOUT_EN
            stall_q     <= '0;
            error_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            write_q     <= write_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            cnt_q       <= cnt_d;
            have_beat_q <= have_beat_d;
            cmd_ready_q <= cmd_ready_d;
            wr_ready_q  <= wr_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_last_q  <= rsp_last_d;
            busy_q      <= busy_d;
            dout_q      <= dout_d;
            drive_q     <= drive_d;
            ncs_q       <= ncs_d;
            nrd_q       <= nrd_d;
            nwe_q       <= nwe_d;
`ifdef USB_MASTER_STALL_TIMEOUT_EN
            stall_q     <= stall_d;
            error_q     <= error_d;
`endif
        end
    end

    assign O_cmd_ready = cmd_ready_q;
    assign O_wr_ready  = wr_ready_q;
    assign O_rsp_valid = rsp_valid_q;
    assign O_rsp_data  = rsp_data_q;
    assign O_rsp_last  = rsp_last_q;
    assign O_busy      = busy_q;
    assign O_usb_addr  = addr_q;
    assign O_usb_dout  = dout_q;
    assign O_usb_drive = drive_q;
    assign O_usb_ncs   = ncs_q;
    assign O_usb_nrd   = nrd_q;
    assign O_usb_nwe   = nwe_q;
`ifdef USB_MASTER_STALL_TIMEOUT_EN
    assign O_error     = error_q;
`else
    assign O_error     = 1'b0;
`endif
endmodule
